// File: rtl/dcache_pkg.sv
// Shared types and geometry for the data cache: FSM state, address field widths, line status record.
package dcache_pkg;

    localparam int ADDR_W        = 32;
    localparam int DATA_W        = 32;
    localparam int SET_BITS_DEF  = 3;
    localparam int WORD_BITS_DEF = 2;
    localparam int SETS_DEF      = 1 << SET_BITS_DEF;
    localparam int WORDS_DEF     = 1 << WORD_BITS_DEF;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL
    } state_t;

    // Tag is everything above index, word and byte fields.
    function automatic int tag_w(input int set_bits, input int word_bits);
        return ADDR_W - set_bits - word_bits - 2;
    endfunction

    // Tag is zero-extended to the full address width so the record shape does not depend on geometry.
    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [ADDR_W-1:0] tag;
    } line_t;

endpackage

// File: rtl/dcache_array.sv
// Cache storage: per-set valid/dirty/tag plus word data; combinational reads, byte-enabled synchronous write.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int SET_BITS  = SET_BITS_DEF,
    parameter int WORD_BITS = WORD_BITS_DEF,
    parameter int TAG_W     = tag_w(SET_BITS, WORD_BITS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SET_BITS-1:0]  rd_idx,
    input  logic [WORD_BITS-1:0] rd_word,
    output line_t                rd_line,
    output logic [DATA_W-1:0]    rd_data,
    input  logic [SET_BITS-1:0]  vic_idx,
    input  logic [WORD_BITS-1:0] vic_word,
    output logic [DATA_W-1:0]    vic_data,
    input  logic                 wr_en,
    input  logic [SET_BITS-1:0]  wr_idx,
    input  logic [WORD_BITS-1:0] wr_word,
    input  logic [3:0]           wr_be,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 set_dirty,
    input  logic                 fill_done,
    input  logic [TAG_W-1:0]     fill_tag
);
    localparam int SETS  = 1 << SET_BITS;
    localparam int WORDS = 1 << WORD_BITS;

    logic [SETS-1:0]                         valid;
    logic [SETS-1:0]                         dirty;
    logic [SETS-1:0][TAG_W-1:0]              tags;
    logic [SETS-1:0][WORDS-1:0][DATA_W-1:0]  data;

    assign rd_line  = '{valid: valid[rd_idx], dirty: dirty[rd_idx], tag: 32'(tags[rd_idx])};
    assign rd_data  = data[rd_idx][rd_word];
    assign vic_data = data[vic_idx][vic_word];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (wr_en && set_dirty)
                dirty[wr_idx] <= 1'b1;
            if (fill_done) begin
                valid[wr_idx] <= 1'b1;
                dirty[wr_idx] <= 1'b0;
            end
        end
    end

    // Contents are meaningless until the valid bit is set, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (wr_be[b])
                    data[wr_idx][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
        end
        if (fill_done)
            tags[wr_idx] <= fill_tag;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller with a word-serial memory port.
// Define DCACHE_STATS_EN to add saturating HitCnt/MissCnt outputs.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int SET_BITS  = SET_BITS_DEF,
    parameter int WORD_BITS = WORD_BITS_DEF
) (
    input  logic        clk,
    input  logic        CpuRst,
    input  logic        RdReq,
    input  logic        WrReq,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic [3:0]  WBe,
    output logic [31:0] RData,
    output logic        DCacheMiss,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] HitCnt,
    output logic [31:0] MissCnt
`endif
);
    localparam int TAG_W  = tag_w(SET_BITS, WORD_BITS);
    localparam int IDX_LO = WORD_BITS + 2;
    localparam int TAG_LO = IDX_LO + SET_BITS;

    logic [TAG_W-1:0]     a_tag;
    logic [SET_BITS-1:0]  a_idx;
    logic [WORD_BITS-1:0] a_word;
    logic                 unused_byte;

    assign a_tag       = Addr[31:TAG_LO];
    assign a_idx       = Addr[TAG_LO-1:IDX_LO];
    assign a_word      = Addr[IDX_LO-1:2];
    assign unused_byte = ^Addr[1:0];

    state_t               state;
    logic [WORD_BITS-1:0] cnt;
    logic [WORD_BITS-1:0] cnt_nxt;
    logic [SET_BITS-1:0]  m_idx;
    logic [TAG_W-1:0]     m_tag;
    line_t                cur;
    logic [31:0]          cur_data;
    logic [31:0]          vic_data;
    logic                 access, hit, cpu_wr, xfer, fill_wr, last;

    assign access     = RdReq | WrReq;
    assign hit        = access && (state == IDLE) && cur.valid && (cur.tag == 32'(a_tag));
    assign DCacheMiss = access && !hit;
    assign RData      = (hit && !WrReq) ? cur_data : '0;
    assign cpu_wr     = hit && WrReq;
    assign xfer       = MemReq && MemAck;
    assign fill_wr    = (state == FILL) && xfer;
    assign last       = (cnt == {WORD_BITS{1'b1}});
    assign cnt_nxt    = cnt + 1'b1;
    // Victim storage cannot change during WB (no hits outside IDLE), so this is stable per word.
    assign MemWData   = (state == WB) ? vic_data : '0;

    dcache_array #(
        .SET_BITS  (SET_BITS),
        .WORD_BITS (WORD_BITS),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (CpuRst),
        .rd_idx    (a_idx),
        .rd_word   (a_word),
        .rd_line   (cur),
        .rd_data   (cur_data),
        .vic_idx   (m_idx),
        .vic_word  (cnt),
        .vic_data  (vic_data),
        .wr_en     (cpu_wr || fill_wr),
        .wr_idx    (fill_wr ? m_idx : a_idx),
        .wr_word   (fill_wr ? cnt : a_word),
        .wr_be     (fill_wr ? 4'hF : WBe),
        .wr_data   (fill_wr ? MemRData : WData),
        .set_dirty (cpu_wr),
        .fill_done (fill_wr && last),
        .fill_tag  (m_tag)
    );

    // Miss address is latched on entry so the CPU may drop or change its access mid-transfer.
    always_ff @(posedge clk or negedge CpuRst) begin
        if (!CpuRst) begin
            state   <= IDLE;
            cnt     <= '0;
            MemReq  <= 1'b0;
            MemWe   <= 1'b0;
            MemAddr <= '0;
            m_idx   <= '0;
            m_tag   <= '0;
        end else begin
            case (state)
                IDLE: if (DCacheMiss) begin
                    m_idx  <= a_idx;
                    m_tag  <= a_tag;
                    cnt    <= '0;
                    MemReq <= 1'b1;
                    if (cur.valid && cur.dirty) begin
                        state   <= WB;
                        MemWe   <= 1'b1;
                        MemAddr <= {cur.tag[TAG_W-1:0], a_idx, {WORD_BITS{1'b0}}, 2'b00};
                    end else begin
                        state   <= FILL;
                        MemWe   <= 1'b0;
                        MemAddr <= {a_tag, a_idx, {WORD_BITS{1'b0}}, 2'b00};
                    end
                end
                WB: if (MemAck) begin
                    cnt <= cnt_nxt;
                    if (last) begin
                        state   <= FILL;
                        MemWe   <= 1'b0;
                        MemAddr <= {m_tag, m_idx, {WORD_BITS{1'b0}}, 2'b00};
                    end else begin
                        MemAddr <= {MemAddr[31:IDX_LO], cnt_nxt, 2'b00};
                    end
                end
                FILL: if (MemAck) begin
                    cnt <= cnt_nxt;
                    if (last) begin
                        state  <= IDLE;
                        MemReq <= 1'b0;
                    end else begin
                        MemAddr <= {MemAddr[31:IDX_LO], cnt_nxt, 2'b00};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge CpuRst) begin
        if (!CpuRst) begin
            HitCnt  <= '0;
            MissCnt <= '0;
        end else begin
            if (hit && (HitCnt != '1))
                HitCnt <= HitCnt + 1'b1;
            if ((state == IDLE) && DCacheMiss && (MissCnt != '1))
                MissCnt <= MissCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: transaction-level cache model checked every cycle, directed scenarios, random traffic.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        CpuRst = 1'b1;
    logic        RdReq = 1'b0, WrReq = 1'b0;
    logic [31:0] Addr = '0, WData = '0;
    logic [3:0]  WBe = '0;
    logic [31:0] RData;
    logic        DCacheMiss;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic        MemAck = 1'b0;
    logic [31:0] MemRData = '0;
`ifdef DCACHE_STATS_EN
    logic [31:0] HitCnt, MissCnt;
`endif

    dcache_ctrl dut (
        .clk        (clk),
        .CpuRst     (CpuRst),
        .RdReq      (RdReq),
        .WrReq      (WrReq),
        .Addr       (Addr),
        .WData      (WData),
        .WBe        (WBe),
        .RData      (RData),
        .DCacheMiss (DCacheMiss),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemAck     (MemAck),
        .MemRData   (MemRData)
`ifdef DCACHE_STATS_EN
        ,
        .HitCnt     (HitCnt),
        .MissCnt    (MissCnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory: word store, configurable ack delay ----------------
    logic [31:0] mem [logic [31:0]];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [31:0] hold_addr, hold_wd;
    logic        hold_we;
    typedef struct { logic we; logic [31:0] addr; } op_t;
    op_t ops[$];

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 3) ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) begin
        #2;
        if (!CpuRst) begin
            MemAck   = 1'b0;
            wait_cnt = 0;
        end else begin
            if (MemAck) wait_cnt = 0;
            MemAck = 1'b0;
            if (wait_cnt > 0) begin
                check("req held while waiting", MemReq, 1'b1);
                if (MemReq) begin
                    check("addr stable", MemAddr, hold_addr);
                    check("we stable", MemWe, hold_we);
                    if (hold_we) check("wdata stable", MemWData, hold_wd);
                end
            end
            if (MemReq) begin
                if (wait_cnt == 0) begin
                    hold_addr = MemAddr;
                    hold_we   = MemWe;
                    hold_wd   = MemWData;
                end
                if (wait_cnt >= ack_delay) begin
                    MemAck = 1'b1;
                    ops.push_back('{we: MemWe, addr: MemAddr});
                    if (MemWe) mem[MemAddr] = MemWData;
                    else       MemRData = memrd(MemAddr);
                end
                wait_cnt++;
            end
        end
    end

    // ---------------- behavioural cache model, compared every cycle ----------------
    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } xfer_t;
    xfer_t       q[$];
    logic        mv [8];
    logic        md [8];
    logic [24:0] mt [8];
    logic [31:0] mdat [8][4];
    int          m_hits = 0, m_misses = 0;

    always @(negedge clk) begin
        logic        acc, hit;
        int          idx, w;
        logic [24:0] tg;
        logic [31:0] er;
        acc = RdReq | WrReq;
        idx = int'(Addr[6:4]);
        w   = int'(Addr[3:2]);
        tg  = Addr[31:7];
        if (!CpuRst) begin
            for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
            q.delete();
            m_hits = 0; m_misses = 0;
            check("reset MemReq", MemReq, 1'b0);
            check("reset MemWe", MemWe, 1'b0);
            check("reset miss", DCacheMiss, acc);
            check("reset rdata", RData, 32'h0);
`ifdef DCACHE_STATS_EN
            check("reset HitCnt", HitCnt, 32'h0);
            check("reset MissCnt", MissCnt, 32'h0);
`endif
        end else begin
`ifdef DCACHE_STATS_EN
            check("HitCnt", HitCnt, m_hits);
            check("MissCnt", MissCnt, m_misses);
`endif
            if (q.size() > 0) begin
                check("busy miss", DCacheMiss, acc);
                check("busy rdata", RData, 32'h0);
                check("busy MemReq", MemReq, 1'b1);
                check("MemWe", MemWe, q[0].we);
                check("MemAddr", MemAddr, q[0].addr);
                if (q[0].we) check("MemWData", MemWData, q[0].data);
                if (MemAck) void'(q.pop_front());
            end else begin
                hit = acc && mv[idx] && (mt[idx] == tg);
                er  = (hit && !WrReq) ? mdat[idx][w] : 32'h0;
                check("miss", DCacheMiss, acc && !hit);
                check("rdata", RData, er);
                check("idle MemReq", MemReq, 1'b0);
                if (hit) m_hits++;
                if (hit && WrReq) begin
                    for (int b = 0; b < 4; b++)
                        if (WBe[b]) mdat[idx][w][8*b +: 8] = WData[8*b +: 8];
                    md[idx] = 1'b1;
                end
                if (acc && !hit) begin
                    m_misses++;
                    if (mv[idx] && md[idx])
                        for (int j = 0; j < 4; j++)
                            q.push_back('{we: 1'b1, addr: {mt[idx], 3'(idx), 2'(j), 2'b00}, data: mdat[idx][j]});
                    for (int j = 0; j < 4; j++) begin
                        q.push_back('{we: 1'b0, addr: {tg, 3'(idx), 2'(j), 2'b00}, data: 32'h0});
                        mdat[idx][j] = memrd({tg, 3'(idx), 2'(j), 2'b00});
                    end
                    mv[idx] = 1'b1;
                    md[idx] = 1'b0;
                    mt[idx] = tg;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        CpuRst = 1'b0;
        tick();
        tick();
        CpuRst = 1'b1;
    endtask

    // Counts cycles with DCacheMiss high; returns at the first negedge where it is low.
    task automatic run_miss(output int n);
        n = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (!DCacheMiss) return;
            n++;
        end
        tests++;
        fails++;
        $display("FAIL miss timeout: still missing after %0d cycles", n);
    endtask

    initial begin
        int n;
        int r;
        bit found;
        mem[32'h10] = 32'h0000_0011;
        mem[32'h14] = 32'h1213_1415;
        mem[32'h18] = 32'h0000_0013;
        mem[32'h1C] = 32'h0000_0014;
        #1;
        do_reset();
        @(negedge clk);
        check("post-reset MemReq", MemReq, 1'b0);
        check("post-reset miss idle", DCacheMiss, 1'b0);
        tick();

        // cold load with single-cycle acks
        ack_delay = 0;
        RdReq = 1'b1; Addr = 32'h10;
        run_miss(n);
        check("cold miss cycles", n, 5);
        check("cold load data", RData, 32'h0000_0011);
        tick();

        // partial store then reload
        RdReq = 1'b0; WrReq = 1'b1; Addr = 32'h14; WData = 32'hAABB_CCDD; WBe = 4'b0011;
        @(negedge clk);
        check("store hit", DCacheMiss, 1'b0);
        tick();
        WrReq = 1'b0; RdReq = 1'b1;
        @(negedge clk);
        check("merged load", RData, 32'h1213_CCDD);
        tick();

        // conflicting load evicts the dirty line first
        ops.delete();
        Addr = 32'h90;
        run_miss(n);
        check("dirty miss cycles", n, 9);
        check("op count", ops.size(), 8);
        for (int i = 0; i < 8 && i < ops.size(); i++) begin
            check("op we", ops[i].we, (i < 4) ? 1'b1 : 1'b0);
            check("op addr", ops[i].addr, (i < 4) ? 32'h10 + 4 * i : 32'h90 + 4 * (i - 4));
        end
        check("wb data 0x14", memrd(32'h14), 32'h1213_CCDD);
        check("wb data 0x10", memrd(32'h10), 32'h0000_0011);
        tick();

        // slow memory: 5 wait cycles per word across writeback and fill
        RdReq = 1'b0; WrReq = 1'b1; Addr = 32'h94; WData = 32'hDEAD_BEEF; WBe = 4'hF;
        @(negedge clk);
        check("slow store hit", DCacheMiss, 1'b0);
        tick();
        ack_delay = 5;
        WrReq = 1'b0; RdReq = 1'b1; Addr = 32'h10;
        run_miss(n);
        check("slow miss cycles", n, 49);
        check("slow load data", RData, 32'h0000_0011);
        check("slow wb data", memrd(32'h94), 32'hDEAD_BEEF);
        tick();

        // reset during the second fill word
        ack_delay = 2;
        Addr = 32'h200;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            tick();
            found = MemReq && (MemAddr == 32'h204);
        end
        check("reached 2nd fill word", found, 1'b1);
        CpuRst = 1'b0;
        #1;
        check("abort MemReq", MemReq, 1'b0);
        RdReq = 1'b0;
        tick();
        tick();
        CpuRst = 1'b1;
        tick();
        check("no req after abort", MemReq, 1'b0);
        RdReq = 1'b1;
        @(negedge clk);
        check("line lost after reset", DCacheMiss, 1'b1);
        run_miss(n);
        check("refill data", RData, memrd(32'h200));
        tick();
        RdReq = 1'b0;
        tick();

`ifdef DCACHE_STATS_EN
        do_reset();
        ack_delay = 0;
        RdReq = 1'b1; Addr = 32'h10;
        run_miss(n);
        tick();
        tick();
        tick();
        RdReq = 1'b0;
        tick();
        check("stats MissCnt", MissCnt, 32'd1);
        check("stats HitCnt", HitCnt, 32'd3);
`endif

        // random traffic over a small tag pool so hits, evictions and mid-miss changes all occur
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) ack_delay = $urandom_range(0, 3);
            CpuRst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            r = $urandom_range(0, 9);
            RdReq = (r < 4);
            WrReq = (r >= 4) && (r < 7);
            if ($urandom_range(0, 9) < 3)
                Addr = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            WData = $urandom;
            WBe   = 4'($urandom_range(0, 15));
            tick();
        end
        CpuRst = 1'b1;
        RdReq = 1'b0;
        WrReq = 1'b0;
        repeat (60) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
